// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 datapath mux, with a registered one-hot grant.
// Define MUX4_ARB_HOLD_LIMIT_EN to force release after MAX_HOLD consecutive cycles.
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [1:0] cur_q, cur_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] gnt_q, gnt_d;

   // Winner is the first requesting index in the order start, start+1, start+2, start+3 (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      rr_pick = start;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   logic [1:0] win;
   logic [1:0] search_start;
   logic       release_now;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hold_expired;
   assign hold_expired = (cnt_q == CW'(MAX_HOLD));
`else
   logic          hold_expired;
   assign hold_expired = 1'b0;
`endif

   assign release_now  = !req[cur_q] || hold_expired;
   assign search_start = (state_q == IDLE) ? ptr_q : cur_q + 2'd1;
   assign win          = rr_pick(req, search_start);

   always_comb begin
      // NOTE: every signal gets its default before any branch, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      cur_d   = cur_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req != 4'b0000) begin
               state_d = GRANT;
               cur_d   = win;
               gnt_d   = 4'b0001 << win;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
               cnt_d   = CW'(1);
`endif
            end
         end
         GRANT: begin
            if (!release_now) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
               if (!hold_expired) cnt_d = cnt_q + CW'(1);
`endif
            end else if (req != 4'b0000) begin
               // The old holder sits last in the search order, so it only wins again if nobody else asks.
               cur_d = win;
               gnt_d = 4'b0001 << win;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
               cnt_d = CW'(1);
`endif
            end else begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               ptr_d   = cur_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= 2'd0;
         ptr_q   <= 2'd0;
         gnt_q   <= 4'b0000;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments make every register update from pre-edge values, matching hardware.
         state_q <= state_d;
         cur_q   <= cur_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign sel  = cur_q;
   assign busy = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; expected values are hand-derived.
// Covers either build of MUX4_ARB_HOLD_LIMIT_EN.
module tb_mux4_rr_arbiter;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   localparam int MAX_HOLD = 2;
`else
   localparam int MAX_HOLD = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   int tests  = 0;
   int errors = 0;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
      check({tag, ".gnt"},  32'(gnt),  32'(eg));
      check({tag, ".sel"},  32'(sel),  32'(es));
      check({tag, ".busy"}, 32'(busy), 32'(eb));
   endtask

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   logic [1:0] rr_sel [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
`endif

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      #12;
      check_out("reset", 4'b0000, 2'd0, 1'b0);
      rst_n = 1'b1;

      // Single requester for 3 cycles, then drop.
      req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("single%0d", i), 4'b0100, 2'd2, 1'b1);
      end
      req = 4'b0000;
      step();
      check_out("single_drop", 4'b0000, 2'd2, 1'b0);

      // Last grantee 2: search order 3,0,1,2 picks 0 from 0101.
      req = 4'b0101;
      step();
      check_out("rr_order", 4'b0001, 2'd0, 1'b1);

      // Back-to-back handover from 0 to 1.
      req = 4'b0011;
      #2;
      req = 4'b0010;
      step();
      check_out("handover", 4'b0010, 2'd1, 1'b1);
      req = 4'b0000;
      step();
      check_out("handover_idle", 4'b0000, 2'd1, 1'b0);

      // Asynchronous reset in the middle of a grant (ptr=2, so 0100 wins).
      req = 4'b0100;
      step();
      check_out("pre_reset", 4'b0100, 2'd2, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 4'b0000, 2'd0, 1'b0);
      req = 4'b1000;
      #3;
      rst_n = 1'b1;
      step();
      check_out("post_reset", 4'b1000, 2'd3, 1'b1);
      req = 4'b0000;
      step();
      check_out("post_reset_idle", 4'b0000, 2'd3, 1'b0);

      // Idle ptr is now 0.
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      req = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         step();
         check_out($sformatf("hold_rr%0d", i), 4'b0001 << rr_sel[i], rr_sel[i], 1'b1);
      end
      // Holder is 0 after the sequence; dropping all requests idles with ptr=1.
      req = 4'b0000;
      step();
      check_out("hold_idle", 4'b0000, 2'd0, 1'b0);
      req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         step();
         check_out($sformatf("hold_lone%0d", i), 4'b0001, 2'd0, 1'b1);
      end
`else
      req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         step();
         check_out($sformatf("nolimit%0d", i), 4'b0001, 2'd0, 1'b1);
      end
      req = 4'b1110;
      step();
      check_out("nolimit_drop", 4'b0010, 2'd1, 1'b1);
`endif

      req = 4'b0000;
      step();
      check("final_idle.busy", 32'(busy), 32'(1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 datapath multiplexer (`Mux4`, `SEL[1:0]`) between four requesters. It samples the request lines and issues a registered one-hot grant. It drives the multiplexer select so that exactly one requester's source reaches the shared bus at a time. It sits beside the shared `Mux4` instance; its `SEL` output connects directly to the mux `SEL` input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold the grant (legal range ≥ 1; used only with the hold limit compiled in).
- `CLK` in 1: sole clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `REQ` in 4: request per requester; level-sensitive, held high until service is finished.
- `GNT` out 4: one-hot grant, or all zero when idle; registered.
- `SEL` out 2: binary index of the current or most recent grantee; drives the `Mux4` `SEL`.
- `BUSY` out 1: equal to `|GNT`.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - `cur` (2 b): current grantee, equal to `SEL`.
  - `ptr` (2 b): next search start.
  - `cnt`: hold counter, width `$clog2(MAX_HOLD+1)`, saturating.
- Winner search: first set bit of `REQ` in order `start`, `start+1`, `start+2`, `start+3`, with indices taken mod 4 (2-bit wrap).
- IDLE:
  - `GNT`=0, `BUSY`=0; `SEL` holds the last grantee.
  - If `REQ`≠0: search from `ptr`, load `cur`/`SEL` = winner, `GNT` = one-hot(winner), `cnt`=1, go to GRANT.
- GRANT, release condition: `REQ[cur]`=0, or (hold limit enabled and `cnt`==`MAX_HOLD`).
- GRANT with no release: keep the grant; `cnt` increments, saturating at `MAX_HOLD`.
- GRANT on release:
  - Search from `cur+1`. The old holder can win again only if it is still requesting, and then only after the other three.
  - If there is a winner: grant it on the same edge (no idle bubble) and set `cnt`=1. `GNT` stays asserted if the winner equals `cur`.
  - If there is no winner: `GNT`=0, `ptr`=`cur+1`, go to IDLE.
- `GNT` always has at most one bit set; `SEL` never changes while `GNT` is held by the same requester.
- `REQ` bits for non-grantees have no effect until a release edge.

## Timing
- Reset (`RST_N`=0), asynchronous and immediate, including in the middle of a grant: `state`=IDLE, `GNT`=0, `BUSY`=0, `SEL`=0, `cur`=0, `ptr`=0, `cnt`=0. The first edge after `RST_N` rises evaluates normally.
- Request-to-grant latency: 1 cycle. `REQ` sampled high at edge N gives `GNT` valid after edge N.
- Release latency: `REQ[cur]` sampled low at edge N removes or transfers the grant after edge N. The requester therefore sees `GNT` for exactly the cycles it held `REQ` high, plus the first (latency) edge offset.
- Hold limit: the holder keeps `GNT` for exactly `MAX_HOLD` cycles, then the transfer occurs at the next edge.
- Handover between requesters is back-to-back: zero idle cycles when another request is pending.
- All outputs are register outputs; there is no combinational `REQ`→`GNT` path.

## Configuration
- `MUX4_ARB_HOLD_LIMIT_EN`:
  - Defined: the `cnt`/`MAX_HOLD` forced-release logic is compiled in, giving bounded wait of at most 3·`MAX_HOLD` cycles plus 1.
  - Undefined: `cnt` is removed and the grant is held until the holder drops `REQ`. Arbitration order and latencies are otherwise identical.

## Test plan
- Reset: assert `RST_N`=0 mid-grant (`GNT`=0100) → `GNT`=0000, `SEL`=0, `BUSY`=0 immediately, without waiting for `CLK`. After release with `REQ`=1000, → `GNT`=1000, `SEL`=3 one edge later.
- Single requester: `REQ`=0100 for 3 cycles → `GNT`=0100, `SEL`=2 for 3 cycles. Then `REQ`=0 → `GNT`=0 after the next edge, `SEL` stays 2.
- Back-to-back handover: holder 0, `REQ`=0011; drop `REQ[0]` → `GNT`=0010, `SEL`=1 on the next edge, with `BUSY` continuously 1.
- Round-robin order: last grantee 2, idle, then `REQ`=0101 → requester 0 granted (search order 3,0,1,2), not 2.
- Hold limit (macro defined, `MAX_HOLD`=2), `REQ`=1111 held → `SEL` sequence 0,0,1,1,2,2,3,3,0,… Lone requester `REQ`=0001 → `GNT`=0001 continuous, `cnt` restarting at 1 every 2 cycles.
- Macro undefined, `REQ`=1111 held for 20 cycles → `GNT`=0001 throughout. Drop `REQ[0]` → `GNT`=0010 on the next edge.
